// File: rtl/pc_gen_pkg.sv
// Shared types and helpers for the fetch-stage PC generator.
// Holds the FSM state encoding, the log2 helper and the redirect priority encoder.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_FENCE = 2'b01
  } pc_state_e;

  // Upper bound on redirect channels accepted by the priority encoder.
  localparam int MAX_REDIRECT = 32;

  function automatic int log2_bytes(input int n);
    int r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) == n) r = i;
    end
    return r;
  endfunction

  // Index of the lowest set bit; 0 when nothing is set (caller qualifies with |vec).
  function automatic int lowest_set(input logic [MAX_REDIRECT-1:0] vec);
    int idx = 0;
    for (int i = MAX_REDIRECT - 1; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack with a saturating count; the oldest entry is overwritten when full.
// Updates one cycle after a request; never stalls, callers gate push/pop/clear themselves.
module ras_stack #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic            clear,
  input  logic [XLEN-1:0] push_addr,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            pop_ok
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] CNT_MAX = (PW+1)'(RAS_DEPTH);

  logic [XLEN-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]   top_ptr;
  logic [PW:0]     cnt;
  logic            wr_en;
  logic [PW-1:0]   wr_ptr;

  assign empty  = (cnt == '0);
  assign top    = mem[top_ptr];
  assign pop_ok = pop && !clear && !empty;

  // A combined push+pop on a non-empty stack replaces the current top in place.
  always_comb begin
    wr_en  = 1'b0;
    wr_ptr = top_ptr;
    if (!clear && push) begin
      wr_en  = 1'b1;
      wr_ptr = pop_ok ? top_ptr : top_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_ptr <= '0;
      cnt     <= '0;
    end else if (clear) begin
      top_ptr <= '0;
      cnt     <= '0;
    end else if (push && !pop_ok) begin
      top_ptr <= top_ptr + PW'(1);
      if (cnt != CNT_MAX) cnt <= cnt + (PW+1)'(1);
    end else if (pop_ok && !push) begin
      top_ptr <= top_ptr - PW'(1);
      cnt     <= cnt - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_addr;
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator: prioritised redirects, stall, FENCE drain and RAS-predicted returns.
// New pc one cycle after redirect/pop/advance; pc advances only when fetch_ready accepts it.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              NUM_REDIRECT = 3,
  parameter int              INSN_BYTES   = 4,
  parameter int              RAS_DEPTH    = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REDIRECT-1:0]      redirect_valid,
  input  logic [NUM_REDIRECT*XLEN-1:0] redirect_target,
  input  logic                         stall,
  input  logic                         fence_req,
  input  logic                         fence_done,
  input  logic                         fetch_ready,
  input  logic                         ras_push,
  input  logic [XLEN-1:0]              ras_push_addr,
  input  logic                         ras_pop,
  input  logic                         ras_clear,
  output logic [XLEN-1:0]              pc,
  output logic                         pc_valid,
  output logic                         fence_busy,
  output logic                         ras_empty,
  output logic                         redirect_misaligned
);

  localparam int              OFS      = log2_bytes(INSN_BYTES);
  localparam logic [XLEN-1:0] LOW_MASK = XLEN'((1 << OFS) - 1);
  localparam logic [XLEN-1:0] INC      = XLEN'(INSN_BYTES);

  pc_state_e                 state_q, state_d;
  logic [XLEN-1:0]           pc_q, pc_d;
  logic                      mis_q, mis_d;
  logic [MAX_REDIRECT-1:0]   redir_vec;
  logic                      any_redir;
  int                        win_idx;
  logic [XLEN-1:0]           win_target;
  logic [XLEN-1:0]           ras_top;
  logic                      ras_pop_ok;
  logic                      ras_is_empty;

  assign redir_vec = MAX_REDIRECT'(redirect_valid);
  assign any_redir = |redirect_valid;

  always_comb begin
    win_idx    = lowest_set(redir_vec);
    win_target = '0;
    for (int i = 0; i < NUM_REDIRECT; i++) begin
      if (i == win_idx) win_target = redirect_target[i*XLEN +: XLEN];
    end
  end

  // Pops only count in RUN; a pop during FENCE would lose the return address without redirecting.
  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push && !stall),
    .pop       (ras_pop && !stall && (state_q == ST_RUN)),
    .clear     (ras_clear && !stall),
    .push_addr (ras_push_addr),
    .top       (ras_top),
    .empty     (ras_is_empty),
    .pop_ok    (ras_pop_ok)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mis_d   = 1'b0;
    if (any_redir) begin
      pc_d    = win_target & ~LOW_MASK;
      mis_d   = |(win_target & LOW_MASK);
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!stall) begin
            if (fence_req)        state_d = ST_FENCE;
            else if (ras_pop_ok)  pc_d    = ras_top;
            else if (fetch_ready) pc_d    = pc_q + INC;
          end
        end
        ST_FENCE: begin
          if (fence_done) begin
            pc_d    = pc_q + INC;
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_VECTOR;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
    end
  end

  assign pc                  = pc_q;
  assign pc_valid            = (state_q == ST_RUN);
  assign fence_busy          = (state_q == ST_FENCE);
  assign ras_empty           = ras_is_empty;
  assign redirect_misaligned = mis_q;

endmodule
